// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Holds the FSM state encoding, the word-size encoding driven on MemSize for
// instruction fetches, the default wait budget and the width helper used by
// the wait timer.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUSY = 2'd1,
        IBUSY = 2'd2
    } arb_state_e;

    localparam logic [1:0]  MEM_SIZE_WORD    = 2'b00;
    localparam int unsigned DEFAULT_MAX_WAIT = 32'd16;

    // Counter width able to hold the values 0..max_wait
    function automatic int unsigned wait_cnt_width(input int unsigned max_wait);
        return $clog2(max_wait + 32'd1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// arb_wait_timer: counts memory wait cycles of the current transaction.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : restart the count (transaction being launched)
//   en_i       : one more cycle waited without MemReady
//   term_o     : the count stands one short of MaxWait, so a further
//                un-ready cycle exhausts the wait budget
module arb_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MaxWait = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int unsigned     CntW     = wait_cnt_width(MaxWait);
    localparam logic [CntW-1:0] LAST_VAL = CntW'(MaxWait - 32'd1);
    localparam logic [CntW-1:0] MAX_VAL  = CntW'(MaxWait);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Next count: clear wins over enable, saturate at MaxWait
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CntW{1'b0}};
        end else if (en_i && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CntW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == LAST_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises Fetch (instruction read) and Memory-stage
// (data read/write) requests onto one single-ported memory, data first.
//   IReq/IAddr -> IData/IValid                 instruction port
//   DReq/DAddr/DWData/DWE/DSize/DExt -> DData/DValid   data port
//   MemReq/MemAddr/MemWData/MemWE/MemSize/MemExt, MemReady/MemRData  memory
//   Stall  : combinational pipeline freeze while a requester waits
//   BusErr : sticky flag, set when a transaction is aborted by the watchdog
// All request fields toward memory are registered and held constant for the
// whole transaction.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MaxWait   = DEFAULT_MAX_WAIT,
    parameter logic [31:0] AbortData = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IData,
    output logic        IValid,
    input  logic        DReq,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    input  logic        DWE,
    input  logic [1:0]  DSize,
    input  logic        DExt,
    output logic [31:0] DData,
    output logic        DValid,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemWE,
    output logic [1:0]  MemSize,
    output logic        MemExt,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic        Stall,
    output logic        BusErr
);

    arb_state_e  state_q,     state_d;
    logic        mem_req_q,   mem_req_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q,    mem_we_d;
    logic [1:0]  mem_size_q,  mem_size_d;
    logic        mem_ext_q,   mem_ext_d;
    logic [31:0] idata_q,     idata_d;
    logic [31:0] ddata_q,     ddata_d;
    logic        ivalid_q,    ivalid_d;
    logic        dvalid_q,    dvalid_d;
    logic        bus_err_q,   bus_err_d;

    logic d_elig_s;
    logic i_elig_s;
    logic busy_s;
    logic done_s;
    logic abort_s;
    logic timer_clr_s;
    logic timer_en_s;
    logic timer_term_s;
    logic [31:0] resp_data_s;

    // A request raised during its own Valid cycle was already served
    assign d_elig_s = DReq & ~dvalid_q;
    assign i_elig_s = IReq & ~ivalid_q;

    assign busy_s  = (state_q == DBUSY) || (state_q == IBUSY);
    assign done_s  = busy_s & MemReady;
    // MemReady in the budget-exhausting cycle counts as completion
    assign abort_s = busy_s & ~MemReady & timer_term_s;
    assign resp_data_s = MemReady ? MemRData : AbortData;

    assign timer_en_s = busy_s & ~MemReady;

    arb_wait_timer #(
        .MaxWait (MaxWait)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (timer_clr_s),
        .en_i   (timer_en_s),
        .term_o (timer_term_s)
    );

    // Next-state, request-field and response logic
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_ext_d   = mem_ext_q;
        idata_d     = idata_q;
        ddata_d     = ddata_q;
        ivalid_d    = 1'b0;
        dvalid_d    = 1'b0;
        bus_err_d   = bus_err_q;
        timer_clr_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_elig_s) begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = DAddr;
                    mem_wdata_d = DWData;
                    mem_we_d    = DWE;
                    mem_size_d  = DSize;
                    mem_ext_d   = DExt;
                    timer_clr_s = 1'b1;
                    state_d     = DBUSY;
                end else if (i_elig_s) begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = IAddr;
                    mem_we_d    = 1'b0;
                    mem_size_d  = MEM_SIZE_WORD;
                    mem_ext_d   = 1'b0;
                    timer_clr_s = 1'b1;
                    state_d     = IBUSY;
                end else begin
                    state_d = IDLE;
                end
            end

            DBUSY: begin
                if (done_s || abort_s) begin
                    dvalid_d = 1'b1;
                    if (!mem_we_q) begin
                        ddata_d = resp_data_s;
                    end else begin
                        ddata_d = ddata_q;
                    end
                    if (abort_s) begin
                        bus_err_d = 1'b1;
                    end else begin
                        bus_err_d = bus_err_q;
                    end
                    // Chain a waiting fetch without dropping MemReq
                    if (i_elig_s) begin
                        mem_req_d   = 1'b1;
                        mem_addr_d  = IAddr;
                        mem_we_d    = 1'b0;
                        mem_size_d  = MEM_SIZE_WORD;
                        mem_ext_d   = 1'b0;
                        timer_clr_s = 1'b1;
                        state_d     = IBUSY;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = DBUSY;
                end
            end

            IBUSY: begin
                if (done_s || abort_s) begin
                    ivalid_d  = 1'b1;
                    idata_d   = resp_data_s;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (abort_s) begin
                        bus_err_d = 1'b1;
                    end else begin
                        bus_err_d = bus_err_q;
                    end
                end else begin
                    state_d = IBUSY;
                end
            end

            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State, request and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_we_q    <= 1'b0;
            mem_size_q  <= MEM_SIZE_WORD;
            mem_ext_q   <= 1'b0;
            idata_q     <= 32'h0000_0000;
            ddata_q     <= 32'h0000_0000;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_ext_q   <= mem_ext_d;
            idata_q     <= idata_d;
            ddata_q     <= ddata_d;
            ivalid_q    <= ivalid_d;
            dvalid_q    <= dvalid_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign MemWE    = mem_we_q;
    assign MemSize  = mem_size_q;
    assign MemExt   = mem_ext_q;
    assign IData    = idata_q;
    assign IValid   = ivalid_q;
    assign DData    = ddata_q;
    assign DValid   = dvalid_q;
    assign BusErr   = bus_err_q;

    assign Stall = ~reset & ((DReq & ~dvalid_q) | (IReq & ~ivalid_q));

endmodule
